// File: rtl/sram_stream_ctrl.sv
// Burst controller that streams write/read data between valid/ready ports and a single-port SRAM.
// Define SRAM_STREAM_WRAP_EN to accept bursts that run past the top word and wrap to address 0.
module sram_stream_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              CEB,
    output logic              WEB,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    localparam int unsigned SumW = LEN_W + 1;
    localparam logic [SumW-1:0] MaxLen = SumW'(2 ** ADDR_W);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_done;
    logic                r_err;
    logic                r_inflight;
    logic [1:0]          r_count;
    logic                r_wptr;
    logic                r_rptr;
    logic [DATA_W-1:0]   r_fifo [2];

    logic                w_cmd_fire;
    logic                w_len_ok;
    logic                w_range_ok;
    logic                w_cmd_ok;
    logic                w_wr_beat;
    logic                w_rd_issue;
    logic                w_rd_room;
    logic                w_pop;
    logic                w_last;
    logic                w_drain_end;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_len_ok   = (cmd_len != '0) && ({1'b0, cmd_len} <= MaxLen);

`ifdef SRAM_STREAM_WRAP_EN
    assign w_range_ok = 1'b1;
`else
    logic [SumW-1:0] w_end;
    assign w_end      = SumW'(cmd_addr) + SumW'(cmd_len);
    assign w_range_ok = (w_end <= MaxLen);
`endif

    assign w_cmd_ok    = w_len_ok && w_range_ok;
    assign w_last      = (r_remaining == LEN_W'(1));
    assign rd_valid    = (r_count != 2'd0);
    assign rd_data     = r_fifo[r_rptr];
    assign w_pop       = rd_valid && rd_ready;
    assign w_drain_end = (r_count == 2'd0) && !r_inflight;

    // A word popped this cycle frees its slot, which keeps a full-rate stream going.
    assign w_rd_room = ((r_count - {1'b0, w_pop} + {1'b0, r_inflight}) < 2'd2);

    assign busy = (r_state != StIdle);
    assign done = r_done;
    assign err  = r_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_cmd_fire && w_cmd_ok) begin
                    w_state_d = cmd_write ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (w_wr_beat && w_last) begin
                    w_state_d = StIdle;
                end
            end
            StRead: begin
                if (w_rd_issue && w_last) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_drain_end) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        CEB        = 1'b1;
        WEB        = 1'b1;
        A          = '0;
        D          = '0;
        w_wr_beat  = 1'b0;
        w_rd_issue = 1'b0;
        case (r_state)
            StIdle: begin
                cmd_ready = 1'b1;
            end
            StWrite: begin
                wr_ready  = 1'b1;
                w_wr_beat = wr_valid;
                CEB       = ~wr_valid;
                WEB       = ~wr_valid;
                A         = r_addr;
                D         = wr_data;
            end
            StRead: begin
                w_rd_issue = w_rd_room;
                CEB        = ~w_rd_room;
                A          = r_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
        end else begin
            if (w_cmd_fire && w_cmd_ok) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_wr_beat || w_rd_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end

            r_done <= (w_wr_beat && w_last) || ((r_state == StDrain) && w_drain_end);
            r_err  <= w_cmd_fire && !w_cmd_ok;

            // SRAM returns Q one cycle after issue; capture it straight into the FIFO.
            r_inflight <= w_rd_issue;
            if (r_inflight) begin
                r_fifo[r_wptr] <= Q;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Scoreboard bench for sram_stream_ctrl: directed bursts against a behavioural SRAM model.
module tb_sram_stream_ctrl;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 12;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              CEB;
    logic              WEB;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D;
    logic [DATA_W-1:0] Q;

    sram_stream_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) u_dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .CEB      (CEB),
        .WEB      (WEB),
        .A        (A),
        .D        (D),
        .Q        (Q)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port SRAM: read data appears the cycle after issue.
    logic [DATA_W-1:0] sram [0:2047];
    logic [DATA_W-1:0] q_r;
    assign Q = q_r;
    always @(posedge CLK) begin
        if (!CEB) begin
            if (!WEB) sram[A] <= D;
            else      q_r     <= sram[A];
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int                off;
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } acc_t;
    typedef struct {
        int                off;
        logic [DATA_W-1:0] d;
    } rd_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];
    int   done_q[$];
    int   err_q[$];

    logic [DATA_W-1:0] exp_mem [0:2047];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got event with value 0x%0h, expected none (t=%0t)", name, act, $time);
    endtask

    task automatic exp_acc(input int off, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        acc_t e;
        e.off = off;
        e.we  = we;
        e.a   = a;
        e.d   = d;
        acc_q.push_back(e);
    endtask

    task automatic exp_rd(input int off, input logic [DATA_W-1:0] d);
        rd_t e;
        e.off = off;
        e.d   = d;
        rd_q.push_back(e);
    endtask

    // Monitor: offsets are counted in cycles from the command-acceptance edge.
    int   acc_cyc  = 0;
    int   off;
    int   n_issued = 0;
    int   n_popped = 0;
    int   dv;
    rd_t  re;
    acc_t ae;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                n_issued = 0;
                n_popped = 0;
            end else begin
                off = cyc - acc_cyc;
                if (rd_valid && rd_ready) begin
                    n_popped++;
                    if (rd_q.size() == 0) begin
                        fail_evt("unexpected_rd_beat", 64'(rd_data));
                    end else begin
                        re = rd_q.pop_front();
                        check("rd_data", 64'(rd_data), 64'(re.d));
                        if (re.off >= 0) check("rd_offset", 64'(off), 64'(re.off));
                    end
                end else if (rd_valid && rd_q.size() != 0) begin
                    check("rd_stall_hold", 64'(rd_data), 64'(rd_q[0].d));
                end
                if (!CEB) begin
                    if (acc_q.size() == 0) begin
                        fail_evt("unexpected_access", 64'({~WEB, A}));
                    end else begin
                        ae = acc_q.pop_front();
                        check("sram_access", 64'({~WEB, A, ae.we ? D : 32'h0}),
                              64'({ae.we, ae.a, ae.we ? ae.d : 32'h0}));
                        if (ae.off >= 0) check("access_offset", 64'(off), 64'(ae.off));
                    end
                    if (WEB) begin
                        check("read_room", 64'((n_issued - n_popped) < 2), 64'(1));
                        n_issued++;
                    end
                end else begin
                    check("web_idle", 64'(WEB), 64'(1));
                end
                check("done_err_excl", 64'(done && err), 64'(0));
                if (done) begin
                    if (done_q.size() == 0) fail_evt("unexpected_done", 64'(off));
                    else begin
                        dv = done_q.pop_front();
                        if (dv >= 0) check("done_offset", 64'(off), 64'(dv));
                    end
                end
                if (err) begin
                    if (err_q.size() == 0) fail_evt("unexpected_err", 64'(off));
                    else begin
                        dv = err_q.pop_front();
                        check("err_offset", 64'(off), 64'(dv));
                    end
                end
                if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                            input logic [DATA_W-1:0] base, input bit ok);
        if (ok) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_acc(i, 1'b1, a + ADDR_W'(i), base + DATA_W'(i));
                exp_mem[a + ADDR_W'(i)] = base + DATA_W'(i);
            end
            done_q.push_back(int'(len));
        end else begin
            err_q.push_back(0);
        end
        send_cmd(1'b1, a, len);
        wr_valid = 1'b1;
        wr_data  = base;
        for (int i = 1; i < int'(len); i++) begin
            @(posedge CLK);
            #1;
            wr_data = base + DATA_W'(i);
        end
        @(posedge CLK);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, input bit timed);
        for (int i = 0; i < int'(len); i++) begin
            exp_acc(timed ? i : -1, 1'b0, a + ADDR_W'(i), 32'h0);
            exp_rd(timed ? i + 2 : -1, exp_mem[a + ADDR_W'(i)]);
        end
        done_q.push_back(timed ? int'(len) + 3 : -1);
        send_cmd(1'b0, a, len);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge CLK);
            #1;
            ok = (acc_q.size() == 0 && rd_q.size() == 0 && done_q.size() == 0 && err_q.size() == 0);
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %0d expected events still pending, 0 required", name,
                      acc_q.size() + rd_q.size() + done_q.size() + err_q.size());
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        #12;
        check("rst_ceb", 64'(CEB), 64'(1));
        check("rst_web", 64'(WEB), 64'(1));
        check("rst_a", 64'(A), 64'(0));
        check("rst_d", 64'(D), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_wr_ready", 64'(wr_ready), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
        check("rel_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rel_busy", 64'(busy), 64'(0));
        check("rel_ceb", 64'(CEB), 64'(1));
        check("rel_a", 64'(A), 64'(0));
        @(posedge CLK);
        #1;

        do_write(11'h010, 12'd4, 32'hA0, 1'b1);
        wait_drain("write_basic");

        rd_ready = 1'b1;
        do_read(11'h010, 12'd4, 1'b1);
        wait_drain("read_basic");

        // Back-pressure pattern 1,0,0 repeating.
        do_read(11'h010, 12'd4, 1'b0);
        for (int i = 0; i < 24; i++) begin
            rd_ready = (i % 3 == 0);
            @(posedge CLK);
            #1;
        end
        rd_ready = 1'b1;
        wait_drain("read_stall");

        err_q.push_back(0);
        send_cmd(1'b0, 11'h020, 12'd0);
        check("len0_busy", 64'(busy), 64'(0));
        wait_drain("reject_len0");

        err_q.push_back(0);
        send_cmd(1'b1, 11'h000, 12'h801);
        check("len2049_busy", 64'(busy), 64'(0));
        wait_drain("reject_len2049");

        do_write(11'h7FC, 12'd4, 32'hC0, 1'b1);
        wait_drain("write_top_exact");

`ifdef SRAM_STREAM_WRAP_EN
        do_write(11'h7FE, 12'd4, 32'hD0, 1'b1);
`else
        do_write(11'h7FE, 12'd4, 32'hD0, 1'b0);
`endif
        wait_drain("write_wrap");

        // Reset three cycles into a len-8 read: only the first three issues and one beat land.
        exp_acc(0, 1'b0, 11'h010, 32'h0);
        exp_acc(1, 1'b0, 11'h011, 32'h0);
        exp_acc(2, 1'b0, 11'h012, 32'h0);
        exp_rd(2, exp_mem[11'h010]);
        send_cmd(1'b0, 11'h010, 12'd8);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("abort_ceb", 64'(CEB), 64'(1));
        check("abort_rd_valid", 64'(rd_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        wait_drain("reset_abort");
        check("abort_idle_ready", 64'(cmd_ready), 64'(1));

        repeat (5) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
